barrett_feeder: RTL and testbench
=================================

BARRETT_FEEDER -- requirements
Module: barrett_feeder

Interface
REQ-001 The module SHALL have parameter DATA_LENGTH, default 64, the width of the product word handed to the Barrett stage.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 8, the operand-pair FIFO depth; it SHALL be a power of two and at least 2.
REQ-003 The module SHALL have port CLK_pci_sys_clk_p, input, 1 bit, the single rising-edge clock.
REQ-004 The module SHALL have port rst_ni, input, 1 bit, a synchronous, active-low reset.
REQ-005 The module SHALL have port a_i, input, DATA_LENGTH/2 bits, operand A.
REQ-006 The module SHALL have port b_i, input, DATA_LENGTH/2 bits, operand B.
REQ-007 The module SHALL have port in_valid_i, input, 1 bit, which qualifies the operand pair.
REQ-008 The module SHALL have port in_ready_o, output, 1 bit, which means the FIFO can accept a pair.
REQ-009 The module SHALL have port en_i, input, 1 bit, which enables issue toward the Barrett stage.
REQ-010 The module SHALL have port flush_i, input, 1 bit, which discards all queued and in-flight data.
REQ-011 The module SHALL have port x_o, output, DATA_LENGTH bits, the product driven to the Barrett x_i input.
REQ-012 The module SHALL have port start_o, output, 1 bit, which qualifies x_o and drives the Barrett start_i input.
REQ-013 The module SHALL have port count_o, output, $clog2(FIFO_DEPTH+1) bits, the current FIFO occupancy.
REQ-014 The module SHALL have port busy_o, output, 1 bit, which is high when the FIFO is non-empty or any pipeline stage is valid.

Function
REQ-015 A pair SHALL be accepted on a rising edge when in_valid_i and in_ready_o are both high.
REQ-016 in_ready_o SHALL equal (count_o != FIFO_DEPTH), so the module SHALL NOT accept a pair while the FIFO is full, even if a pop occurs in the same cycle.
REQ-017 A pop SHALL occur on an edge when the FIFO is non-empty and en_i is high; there SHALL be no backpressure from downstream.
REQ-018 The popped pair SHALL be registered into stage 1 on the pop edge; stage 2 SHALL register the full a*b product, DATA_LENGTH bits unsigned and not truncated, on the following edge.
REQ-019 Latency SHALL be exactly 2 edges from pop to start_o: with a pair accepted at edge k and en_i high, start_o SHALL be high in the cycle after edge k+2.
REQ-020 start_o SHALL be a single-cycle pulse per product; back-to-back pops SHALL yield consecutive start_o cycles at one product per clock.
REQ-021 x_o SHALL hold its last value while start_o is low.
REQ-022 Products SHALL emerge in acceptance order.
REQ-023 On a simultaneous push and pop, count_o SHALL be unchanged and both operations SHALL occur.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH with no lost or duplicated entries.
REQ-025 When en_i is deasserted, pops SHALL stop, but pairs already in stage 1 or stage 2 SHALL drain normally.
REQ-026 When flush_i is high at an edge, the module SHALL empty the FIFO, clear both stage valid bits, and drop any push or pop in that cycle; flush SHALL take priority over push and pop.
REQ-027 The module SHALL have no state machine beyond the FIFO pointers and the two stage valid bits.

Reset
REQ-028 When rst_ni is low at a rising edge, the module SHALL clear the FIFO pointers and both stage valid bits and set x_o to 0.
REQ-029 Reset SHALL force start_o=0, count_o=0, busy_o=0 and in_ready_o=1 from that edge.
REQ-030 Reset SHALL take priority over flush_i, push and pop.
REQ-031 Reset asserted mid-stream SHALL discard all in-flight products, and no start_o pulse SHALL appear for them.

Configuration
REQ-032 When macro BARRETT_FEEDER_PASSTHRU_EN is defined, the module SHALL add input passthru_i (1 bit), stored per FIFO entry alongside the operands.
REQ-033 With the macro defined, an entry with passthru_i=1 SHALL produce x_o = {a_i, b_i} (A in the upper half), and an entry with passthru_i=0 SHALL produce the product; latency SHALL be identical for both.
REQ-034 When the macro is undefined, port passthru_i SHALL be absent and every entry SHALL be multiplied.

Verification
REQ-035 Basic product: DATA_LENGTH=64, en_i=1, push a=3, b=5 at edge k -> start_o high after edge k+2 with x_o=0x000000000000000F, and busy_o=0 afterwards.
REQ-036 Full boundary: en_i=0, in_valid_i held high with 9 pairs -> 8 accepted, count_o=8, in_ready_o=0; then raise en_i -> 8 consecutive start_o pulses in order, with a=b=0xFFFFFFFF giving x_o=0xFFFFFFFE00000001.
REQ-037 Streaming with wrap: 20 pairs (i, i+1) pushed continuously with en_i=1 -> 20 contiguous start_o pulses with x_o=i*(i+1), count_o never above 1.
REQ-038 Flush: 4 entries queued and 2 in flight, flush_i pulsed one cycle -> no further start_o, count_o=0, busy_o=0 on the next cycle.
REQ-039 Reset mid-stream: rst_ni low one edge while start_o is pulsing -> start_o=0, x_o=0, count_o=0 and in_ready_o=1 from that edge.
REQ-040 Passthrough (macro defined): push a=0x1, b=0x2 with passthru_i=1 -> x_o=0x0000000100000002 after 2 edges.

Source files
------------

// File: rtl/barrett_feeder.sv
// rtl/barrett_feeder.sv - operand-pair FIFO and two-stage multiplier feeding a Barrett reducer
// Optional macro BARRETT_FEEDER_PASSTHRU_EN adds passthru_i; such entries issue {a,b} unmultiplied.
module barrett_feeder #(
   parameter int DATA_LENGTH = 64,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                             CLK_pci_sys_clk_p,
   input  logic                             rst_ni,
   input  logic [DATA_LENGTH/2-1:0]         a_i,
   input  logic [DATA_LENGTH/2-1:0]         b_i,
   input  logic                             in_valid_i,
   output logic                             in_ready_o,
   input  logic                             en_i,
   input  logic                             flush_i,
`ifdef BARRETT_FEEDER_PASSTHRU_EN
   input  logic                             passthru_i,
`endif
   output logic [DATA_LENGTH-1:0]           x_o,
   output logic                             start_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o,
   output logic                             busy_o
);

   localparam int HW = DATA_LENGTH / 2;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
`ifdef BARRETT_FEEDER_PASSTHRU_EN
   localparam int EW = DATA_LENGTH + 1;
`else
   localparam int EW = DATA_LENGTH;
`endif

   logic [EW-1:0]          mem_q [FIFO_DEPTH];
   logic [EW-1:0]          mem_d [FIFO_DEPTH];
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   s1_valid_q, s1_valid_d;
   logic [EW-1:0]          s1_entry_q, s1_entry_d;
   logic                   s2_valid_q, s2_valid_d;
   logic [DATA_LENGTH-1:0] x_q, x_d;

   logic                   push;
   logic                   pop;
   logic [EW-1:0]          entry_in;
   logic [DATA_LENGTH-1:0] s1_product;
   logic [DATA_LENGTH-1:0] s1_result;

   // The low DATA_LENGTH bits of an entry are {a, b}, which is also the passthrough word.
`ifdef BARRETT_FEEDER_PASSTHRU_EN
   assign entry_in  = {passthru_i, a_i, b_i};
`else
   assign entry_in  = {a_i, b_i};
`endif

   assign s1_product = DATA_LENGTH'(s1_entry_q[DATA_LENGTH-1:HW]) * DATA_LENGTH'(s1_entry_q[HW-1:0]);

`ifdef BARRETT_FEEDER_PASSTHRU_EN
   assign s1_result = s1_entry_q[EW-1] ? s1_entry_q[DATA_LENGTH-1:0] : s1_product;
`else
   assign s1_result = s1_product;
`endif

   // A full FIFO refuses a push even when a pop frees a slot on the same edge.
   assign push = in_valid_i && (count_q != CW'(FIFO_DEPTH));
   assign pop  = (count_q != '0) && en_i;

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      s1_valid_d = s1_valid_q;
      s1_entry_d = s1_entry_q;
      s2_valid_d = s2_valid_q;
      x_d        = x_q;
      if (flush_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = entry_in;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            s1_entry_d = mem_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + PW'(1);
         end
         s1_valid_d = pop;
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            x_d = s1_result;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge CLK_pci_sys_clk_p) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         s1_valid_q <= 1'b0;
         s1_entry_q <= '0;
         s2_valid_q <= 1'b0;
         x_q        <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         s1_valid_q <= s1_valid_d;
         s1_entry_q <= s1_entry_d;
         s2_valid_q <= s2_valid_d;
         x_q        <= x_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count alone.
   always_ff @(posedge CLK_pci_sys_clk_p) begin
      mem_q <= mem_d;
   end

   assign in_ready_o = (count_q != CW'(FIFO_DEPTH));
   assign x_o        = x_q;
   assign start_o    = s2_valid_q;
   assign count_o    = count_q;
   assign busy_o     = (count_q != '0) || s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_barrett_feeder.sv
// tb/tb_barrett_feeder.sv - scoreboard bench for barrett_feeder
// Define BARRETT_FEEDER_PASSTHRU_EN for both files to cover the passthrough entries.
module tb_barrett_feeder;

   localparam int DL    = 64;
   localparam int DEPTH = 8;
`ifdef BARRETT_FEEDER_PASSTHRU_EN
   localparam bit PT_EN = 1'b1;
`else
   localparam bit PT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   a, b;
   logic          in_valid, en, flush, passthru;
   logic          in_ready_o, start_o, busy_o;
   logic [DL-1:0] x_o;
   logic [3:0]    count_o;

   int            checks = 0;
   int            failures = 0;
   logic [63:0]   exp_q[$];
   int            mcount = 0;
   int            cyc = 0;
   int            starts = 0;
   int            first_start = -1;
   int            last_start = -1;
   int            max_count = 0;

   always #5 clk = ~clk;

   barrett_feeder #(.DATA_LENGTH(DL), .FIFO_DEPTH(DEPTH)) dut (
      .CLK_pci_sys_clk_p (clk),
      .rst_ni            (rst_n),
      .a_i               (a),
      .b_i               (b),
      .in_valid_i        (in_valid),
      .in_ready_o        (in_ready_o),
      .en_i              (en),
      .flush_i           (flush),
`ifdef BARRETT_FEEDER_PASSTHRU_EN
      .passthru_i        (passthru),
`endif
      .x_o               (x_o),
      .start_o           (start_o),
      .count_o           (count_o),
      .busy_o            (busy_o)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic clear_stats();
      starts      = 0;
      first_start = -1;
      last_start  = -1;
      max_count   = 0;
   endtask

   // One clock: drive inputs, let the edge happen, update the reference model, then sample.
   task automatic cycle(input logic v, input logic [31:0] av, input logic [31:0] bv,
                        input logic e, input logic f, input logic pt);
      logic acc;
      logic popm;
      in_valid = v;
      a        = av;
      b        = bv;
      en       = e;
      flush    = f;
      passthru = pt;
      @(posedge clk);
      cyc++;
      if (f) begin
         exp_q.delete();
         mcount = 0;
      end else begin
         acc  = v && (mcount != DEPTH);
         popm = (mcount != 0) && e;
         if (acc) exp_q.push_back((pt && PT_EN) ? {av, bv} : {32'b0, av} * {32'b0, bv});
         mcount = mcount + int'(acc) - int'(popm);
      end
      #1;
      if (start_o) begin
         starts++;
         if (first_start < 0) first_start = cyc;
         last_start = cyc;
      end
      if (int'(count_o) > max_count) max_count = int'(count_o);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      cyc++;
      exp_q.delete();
      mcount = 0;
      #1;
      check_eq("rst_start", start_o, 0);
      check_eq("rst_x", x_o, 0);
      check_eq("rst_count", count_o, 0);
      check_eq("rst_ready", in_ready_o, 1);
      check_eq("rst_busy", busy_o, 0);
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check_eq("count", count_o, mcount);
         check_eq("ready", in_ready_o, mcount != DEPTH);
         if (start_o) begin
            if (exp_q.size() == 0) check_eq("spurious_start", start_o, 0);
            else check_eq("x_o", x_o, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [31:0] ra, rb;
      rst_n = 1'b0; in_valid = 0; a = 0; b = 0; en = 0; flush = 0; passthru = 0;
      do_reset();

      // Basic product and latency
      cycle(1, 3, 5, 1, 0, 0);
      check_eq("basic_lat0", start_o, 0);
      cycle(0, 0, 0, 1, 0, 0);
      check_eq("basic_lat1", start_o, 0);
      cycle(0, 0, 0, 1, 0, 0);
      check_eq("basic_start", start_o, 1);
      check_eq("basic_x", x_o, 64'h000000000000000F);
      cycle(0, 0, 0, 1, 0, 0);
      check_eq("basic_pulse", start_o, 0);
      check_eq("basic_busy", busy_o, 0);
      check_eq("x_hold", x_o, 64'h000000000000000F);

      // Fill to the boundary with issue disabled
      for (int i = 0; i < 9; i++) begin
         ra = (i == 0) ? 32'hFFFFFFFF : $urandom;
         rb = (i == 0) ? 32'hFFFFFFFF : $urandom;
         cycle(1, ra, rb, 0, 0, 0);
      end
      check_eq("full_count", count_o, 8);
      check_eq("full_ready", in_ready_o, 0);
      check_eq("full_busy", busy_o, 1);
      clear_stats();
      cycle(1, 32'h1234, 32'h5678, 1, 0, 0);
      for (int i = 0; i < 11; i++) cycle(0, 0, 0, 1, 0, 0);
      check_eq("full_starts", starts, 8);
      check_eq("full_contig", last_start - first_start, 7);

      // Continuous streaming across pointer wrap
      clear_stats();
      for (int i = 0; i < 20; i++) cycle(1, i, i + 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 0);
      check_eq("stream_starts", starts, 20);
      check_eq("stream_contig", last_start - first_start, 19);
      check_eq("stream_max_count", max_count, 1);

      // Flush with 4 queued and 2 in flight, plus a simultaneous push
      for (int i = 0; i < 6; i++) cycle(1, $urandom, $urandom, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 1, 0, 0);
      check_eq("flush_pre_count", count_o, 4);
      check_eq("flush_pre_start", start_o, 1);
      cycle(1, $urandom, $urandom, 1, 1, 0);
      check_eq("flush_start", start_o, 0);
      check_eq("flush_count", count_o, 0);
      check_eq("flush_busy", busy_o, 0);
      clear_stats();
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 0, 0);
      check_eq("flush_no_starts", starts, 0);

      // Reset while products are streaming out
      for (int i = 0; i < 4; i++) cycle(1, i + 7, i + 9, 1, 0, 0);
      check_eq("midrst_pre_start", start_o, 1);
      do_reset();
      clear_stats();
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0, 0);
      check_eq("midrst_no_starts", starts, 0);

`ifdef BARRETT_FEEDER_PASSTHRU_EN
      cycle(1, 1, 2, 1, 0, 1);
      cycle(0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 1, 0, 0);
      check_eq("pt_start", start_o, 1);
      check_eq("pt_x", x_o, 64'h0000000100000002);
      cycle(1, 6, 7, 1, 0, 0);
      cycle(1, 6, 7, 1, 0, 1);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 0);
`endif

      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 0);
      check_eq("sb_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
